// File: rtl/snake_step_sequencer.sv
// snake_step_sequencer: once per move tick, advances the snake head one cell,
// detects walls and food, maintains the circular body buffer, length and score,
// and issues erase-tail / draw-head requests to the plotter over req/ack.
// Optional feature macro: SNAKE_SELF_COLLIDE_EN adds a SCAN state that checks the
// next head against the body, one entry per cycle.
module snake_step_sequencer #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int TICK_DIV = 5000000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [2:0]     dir,
    input  logic [X_W-1:0] food_x,
    input  logic [Y_W-1:0] food_y,
    input  logic           draw_ack,
    output logic           draw_req,
    output logic [X_W-1:0] draw_x,
    output logic [Y_W-1:0] draw_y,
    output logic           draw_colour,
    output logic           food_eaten,
    output logic           game_over,
    output logic [7:0]     score,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic           busy
);

    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = PTR_W + 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [Y_W-1:0] INIT_Y = Y_W'(GRID_H / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_STEP,
        S_COMMIT,
        S_ERASE,
        S_DRAW,
        S_DEAD
`ifdef SNAKE_SELF_COLLIDE_EN
        , S_SCAN
`endif
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [X_W-1:0]       r_body_x [MAX_LEN];
    logic [Y_W-1:0]       r_body_y [MAX_LEN];
    logic [PTR_W-1:0]     r_head_ptr;
    logic [LEN_W-1:0]     r_len;
    logic [7:0]           r_score;
    logic [X_W-1:0]       r_head_x;
    logic [Y_W-1:0]       r_head_y;
    logic [X_W-1:0]       r_next_x;
    logic [Y_W-1:0]       r_next_y;
    logic [X_W-1:0]       r_tail_x;
    logic [Y_W-1:0]       r_tail_y;
    logic                 r_grow;
    logic                 r_food_eaten;

    logic [X_W-1:0]       w_nx;
    logic [Y_W-1:0]       w_ny;
    logic                 w_wall;
    logic                 w_food_hit;
    logic                 w_tick_done;
    logic                 w_restart;
    logic                 w_grow_room;
    logic [PTR_W-1:0]     w_ptr_inc;
    logic [PTR_W-1:0]     w_tail_ptr;

`ifdef SNAKE_SELF_COLLIDE_EN
    logic [PTR_W-1:0]     r_scan_idx;
    logic [PTR_W-1:0]     w_scan_ptr;
    logic [LEN_W-1:0]     w_scan_cnt;
    logic                 w_scan_hit;
    logic                 w_scan_last;
`endif

    // Saturating +1 for the 8-bit score.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reset-time x of body buffer entry i (entry INIT_LEN-1 is the head).
    function automatic logic [X_W-1:0] init_x(input int i);
        return X_W'(GRID_W / 2 + INIT_LEN - 1 - i);
    endfunction

    assign w_tick_done = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign w_restart   = (r_state == S_DEAD) && start;
    assign w_ptr_inc   = r_head_ptr + PTR_W'(1);
    assign w_tail_ptr  = r_head_ptr - PTR_W'(r_len - LEN_W'(1));
    assign w_grow_room = r_grow && (r_len < LEN_W'(MAX_LEN));
    assign w_food_hit  = (w_nx == food_x) && (w_ny == food_y);

`ifdef SNAKE_SELF_COLLIDE_EN
    // The tail cell vacates during a plain move, so it only counts when growing.
    assign w_scan_ptr  = r_head_ptr - r_scan_idx;
    assign w_scan_cnt  = r_grow ? r_len : (r_len - LEN_W'(1));
    assign w_scan_hit  = (r_body_x[w_scan_ptr] == r_next_x) && (r_body_y[w_scan_ptr] == r_next_y);
    assign w_scan_last = ({1'b0, r_scan_idx} == (w_scan_cnt - LEN_W'(1)));
`endif

    // Candidate next head cell and wall detection from the current direction.
    always_comb begin
        w_nx   = r_head_x;
        w_ny   = r_head_y;
        w_wall = 1'b0;
        if (dir[2]) begin
            if (!dir[1]) begin
                if (r_head_y == '0) w_wall = 1'b1;
                else                w_ny   = r_head_y - Y_W'(1);
            end else begin
                if (r_head_y == Y_W'(GRID_H - 1)) w_wall = 1'b1;
                else                              w_ny   = r_head_y + Y_W'(1);
            end
        end else begin
            if (!dir[0]) begin
                if (r_head_x == '0) w_wall = 1'b1;
                else                w_nx   = r_head_x - X_W'(1);
            end else begin
                if (r_head_x == X_W'(GRID_W - 1)) w_wall = 1'b1;
                else                              w_nx   = r_head_x + X_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic and plotter-facing outputs.
    always_comb begin
        w_state_nxt = r_state;
        draw_req    = 1'b0;
        draw_colour = 1'b0;
        draw_x      = r_head_x;
        draw_y      = r_head_y;
        game_over   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                busy = 1'b0;
                if (w_tick_done) w_state_nxt = S_STEP;
            end
            S_STEP: begin
`ifdef SNAKE_SELF_COLLIDE_EN
                w_state_nxt = w_wall ? S_DEAD : S_SCAN;
`else
                w_state_nxt = w_wall ? S_DEAD : S_COMMIT;
`endif
            end
`ifdef SNAKE_SELF_COLLIDE_EN
            S_SCAN: begin
                if (w_scan_hit)       w_state_nxt = S_DEAD;
                else if (w_scan_last) w_state_nxt = S_COMMIT;
            end
`endif
            S_COMMIT: begin
                w_state_nxt = w_grow_room ? S_DRAW : S_ERASE;
            end
            S_ERASE: begin
                draw_req = 1'b1;
                draw_x   = r_tail_x;
                draw_y   = r_tail_y;
                if (draw_ack) w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                draw_req    = 1'b1;
                draw_colour = 1'b1;
                if (draw_ack) w_state_nxt = S_WAIT_TICK;
            end
            S_DEAD: begin
                busy      = 1'b0;
                game_over = 1'b1;
                if (start) w_state_nxt = S_WAIT_TICK;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Move-tick divider; held at zero outside WAIT_TICK so every entry restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                  r_cnt <= '0;
        else if (r_state == S_WAIT_TICK && !w_tick_done) r_cnt <= r_cnt + CNT_W'(1);
        else                                           r_cnt <= '0;
    end

    // Circular body buffer: initial snake on reset/restart, new head written on commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_body_x[i] <= (i < INIT_LEN) ? init_x(i) : '0;
                r_body_y[i] <= (i < INIT_LEN) ? INIT_Y : '0;
            end
        end else if (w_restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_body_x[i] <= (i < INIT_LEN) ? init_x(i) : '0;
                r_body_y[i] <= (i < INIT_LEN) ? INIT_Y : '0;
            end
        end else if (r_state == S_COMMIT) begin
            r_body_x[w_ptr_inc] <= r_next_x;
            r_body_y[w_ptr_inc] <= r_next_y;
        end
    end

    // Step bookkeeping: next head, grow flag, pointer, length, score and tail capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head_ptr   <= PTR_W'(INIT_LEN - 1);
            r_len        <= LEN_W'(INIT_LEN);
            r_score      <= '0;
            r_head_x     <= X_W'(GRID_W / 2);
            r_head_y     <= INIT_Y;
            r_next_x     <= '0;
            r_next_y     <= '0;
            r_tail_x     <= '0;
            r_tail_y     <= '0;
            r_grow       <= 1'b0;
            r_food_eaten <= 1'b0;
`ifdef SNAKE_SELF_COLLIDE_EN
            r_scan_idx   <= '0;
`endif
        end else begin
            r_food_eaten <= 1'b0;
            case (r_state)
                S_STEP: begin
                    r_next_x     <= w_nx;
                    r_next_y     <= w_ny;
                    r_grow       <= w_food_hit && !w_wall;
                    r_food_eaten <= w_food_hit && !w_wall;
`ifdef SNAKE_SELF_COLLIDE_EN
                    r_scan_idx   <= '0;
`endif
                end
`ifdef SNAKE_SELF_COLLIDE_EN
                S_SCAN: r_scan_idx <= r_scan_idx + PTR_W'(1);
`endif
                S_COMMIT: begin
                    r_head_ptr <= w_ptr_inc;
                    r_head_x   <= r_next_x;
                    r_head_y   <= r_next_y;
                    r_tail_x   <= r_body_x[w_tail_ptr];
                    r_tail_y   <= r_body_y[w_tail_ptr];
                    if (r_grow)      r_score <= sat_inc8(r_score);
                    if (w_grow_room) r_len   <= r_len + LEN_W'(1);
                end
                S_DEAD: begin
                    if (start) begin
                        r_head_ptr <= PTR_W'(INIT_LEN - 1);
                        r_len      <= LEN_W'(INIT_LEN);
                        r_score    <= '0;
                        r_head_x   <= X_W'(GRID_W / 2);
                        r_head_y   <= INIT_Y;
                        r_grow     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign food_eaten = r_food_eaten;
    assign score      = r_score;
    assign head_x     = r_head_x;
    assign head_y     = r_head_y;

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Directed bench for snake_step_sequencer with TICK_DIV=4 and default geometry.
module tb_snake_step_sequencer;

    localparam int X_W  = 6;
    localparam int Y_W  = 5;
    localparam int TICK = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     dir = 3'b000;
    logic [X_W-1:0] food_x = '0;
    logic [Y_W-1:0] food_y = '0;
    logic           draw_ack = 1'b0;
    logic           draw_req;
    logic [X_W-1:0] draw_x;
    logic [Y_W-1:0] draw_y;
    logic           draw_colour;
    logic           food_eaten;
    logic           game_over;
    logic [7:0]     score;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic           busy;

    always #5 clk = ~clk;

    snake_step_sequencer #(
        .GRID_W(40), .GRID_H(30), .X_W(X_W), .Y_W(Y_W),
        .MAX_LEN(32), .INIT_LEN(3), .TICK_DIV(TICK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dir(dir),
        .food_x(food_x), .food_y(food_y), .draw_ack(draw_ack),
        .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y),
        .draw_colour(draw_colour), .food_eaten(food_eaten),
        .game_over(game_over), .score(score), .head_x(head_x),
        .head_y(head_y), .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // results of the most recent move
    int m_nerase, m_ndraw, m_exy, m_dxy;
    int m_eaten, m_dead;

    typedef struct {
        logic [2:0] d;
        int fx;
        int fy;
        int nerase;
        int exy;
        int dxy;
        int hxy;
        int sc;
        int eat;
    } vec_t;

    vec_t tv [5];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_food(input int fx, input int fy);
        food_x = X_W'(fx);
        food_y = Y_W'(fy);
    endtask

    function automatic int hxy();
        return int'(head_x) * 100 + int'(head_y);
    endfunction

    // One move tick with draw_ack held high; records plot requests and pulses.
    task automatic do_move();
        int cyc;
        m_nerase = 0; m_ndraw = 0; m_exy = -1; m_dxy = -1; m_eaten = 0; m_dead = 0;
        cyc = 0;
        while (!busy && !game_over && cyc < TICK + 6) begin
            tick();
            cyc++;
        end
        if (!busy) begin
            chk("move_start_timeout", 0, 1);
            return;
        end
        cyc = 0;
        while (busy && cyc < 80) begin
            if (food_eaten) m_eaten = 1;
            if (draw_req) begin
                if (draw_colour) begin
                    m_ndraw++;
                    m_dxy = int'(draw_x) * 100 + int'(draw_y);
                end else begin
                    m_nerase++;
                    m_exy = int'(draw_x) * 100 + int'(draw_y);
                end
            end
            tick();
            cyc++;
        end
        if (busy) chk("move_end_timeout", 0, 1);
        m_dead = int'(game_over);
    endtask

    initial begin
        int bad;
        int cyc;
        int tot_erase;
        int tot_eaten;

        tv[0] = '{3'b000,  0,  0, 1, 2215, 1915, 1915, 0, 0};
        tv[1] = '{3'b000, 18, 15, 0,   -1, 1815, 1815, 1, 1};
        tv[2] = '{3'b100,  0,  0, 1, 2115, 1814, 1814, 1, 0};
        tv[3] = '{3'b001,  0,  0, 1, 2015, 1914, 1914, 1, 0};
        tv[4] = '{3'b110,  0,  0, 1, 1915, 1915, 1915, 1, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", int'(draw_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_food_eaten", int'(food_eaten), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_head", hxy(), 2015);
        reset_n = 1'b1;
        repeat (8) tick();
        chk("idle_no_move", int'(busy) + int'(draw_req) + hxy(), 2015);

        pulse_start();
        draw_ack = 1'b1;

        // table-driven moves
        for (int i = 0; i < 5; i++) begin
            dir = tv[i].d;
            set_food(tv[i].fx, tv[i].fy);
            do_move();
            chk($sformatf("v%0d_nerase", i), m_nerase, tv[i].nerase);
            chk($sformatf("v%0d_erase_xy", i), m_exy, tv[i].exy);
            chk($sformatf("v%0d_ndraw", i), m_ndraw, 1);
            chk($sformatf("v%0d_draw_xy", i), m_dxy, tv[i].dxy);
            chk($sformatf("v%0d_head", i), hxy(), tv[i].hxy);
            chk($sformatf("v%0d_score", i), int'(score), tv[i].sc);
            chk($sformatf("v%0d_eaten", i), m_eaten, tv[i].eat);
            chk($sformatf("v%0d_dead", i), m_dead, 0);
        end

        // slow plotter and spurious ack
        draw_ack = 1'b0;
        dir = 3'b000;
        set_food(39, 29);
        draw_ack = 1'b1;
        tick();
        draw_ack = 1'b0;
        chk("spurious_ack", int'(draw_req) + int'(busy), 0);
        cyc = 0;
        while (!draw_req && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("slow_erase_req", int'(draw_req), 1);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (!(draw_req && !draw_colour && draw_x == X_W'(18) && draw_y == Y_W'(15))) bad++;
            if (k < 7) tick();
        end
        chk("slow_erase_hold", bad, 0);
        draw_ack = 1'b1;
        tick();
        draw_ack = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (!(draw_req && draw_colour && draw_x == X_W'(18) && draw_y == Y_W'(15))) bad++;
            if (k < 3) tick();
        end
        chk("slow_draw_hold", bad, 0);
        draw_ack = 1'b1;
        tick();
        chk("req_drop_after_ack", int'(draw_req), 0);
        chk("slow_head", hxy(), 1815);

        // run into the left wall, then restart
        for (int k = 0; k < 18; k++) do_move();
        chk("run_to_wall_head", hxy(), 15);
        do_move();
        chk("wall_no_req", m_nerase + m_ndraw, 0);
        chk("wall_dead", int'(game_over), 1);
        chk("wall_head", hxy(), 15);
        repeat (10) tick();
        chk("dead_hold", int'(game_over) * 10000 + hxy(), 10015);
        pulse_start();
        chk("restart_game_over", int'(game_over), 0);
        chk("restart_head", hxy(), 2015);
        chk("restart_score", int'(score), 0);

        // grow to length 5, then turn up/right/down into the body
        set_food(19, 15); do_move();
        set_food(18, 15); do_move();
        chk("grow5_score", int'(score), 2);
        set_food(39, 29);
        dir = 3'b100; do_move();
        dir = 3'b001; do_move();
        dir = 3'b110; do_move();
`ifdef SNAKE_SELF_COLLIDE_EN
        chk("collide_dead", m_dead, 1);
        chk("collide_no_req", m_nerase + m_ndraw, 0);
        chk("collide_head", hxy(), 1914);
`else
        chk("pass_through_dead", m_dead, 0);
        chk("pass_through_erase", m_exy, 2015);
        chk("pass_through_draw", m_dxy, 1915);
`endif
        pulse_start();

        // reset in the middle of a handshake
        draw_ack = 1'b0;
        dir = 3'b000;
        cyc = 0;
        while (!draw_req && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("midreq_seen", int'(draw_req), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_req", int'(draw_req), 0);
        chk("async_reset_head", hxy(), 2015);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        draw_ack = 1'b1;
        pulse_start();

        // feed until the length saturates
        tot_erase = 0;
        tot_eaten = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k <= 19) begin
                dir = 3'b000;
                set_food(20 - k, 15);
            end else begin
                dir = 3'b100;
                set_food(1, 15 - (k - 19));
            end
            do_move();
            if (k < 30) begin
                tot_erase += m_nerase;
                tot_eaten += m_eaten;
            end
        end
        chk("feed_no_erase", tot_erase, 0);
        chk("feed_eaten_count", tot_eaten, 29);
        chk("full_eaten", m_eaten, 1);
        chk("full_erase_tail", m_exy, 2215);
        chk("full_draw", m_dxy, 104);
        chk("full_score", int'(score), 30);
        set_food(39, 29);
        do_move();
        chk("after_full_erase", m_exy, 2115);
        chk("after_full_draw", m_dxy, 103);
        chk("after_full_score", int'(score), 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
